// File: rtl/csr_io_arbiter.sv
// Two-master arbiter for the CSR I/O port: turns a held request from master A or B
// into a single-cycle io_rd/io_wr strobe, captures read data and returns a one-cycle ack.
module csr_io_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [15:0] io_din,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t      state;
  logic        own_b;
  logic        we_q;
  logic        last_b;
  logic        grant_b;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // On contention, fixed priority always picks A; round-robin picks the master
  // that did not win last time.
  always_comb begin
    grant_b = 1'b0;
    if (a_req && b_req) begin
      grant_b = (FIXED_PRIO != 0) ? 1'b0 : ~last_b;
    end else begin
      grant_b = b_req;
    end
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      own_b   <= 1'b0;
      we_q    <= 1'b0;
      last_b  <= 1'b1;
      io_addr <= '0;
      io_dout <= '0;
      io_wr   <= 1'b0;
      io_rd   <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            own_b   <= grant_b;
            last_b  <= grant_b;
            we_q    <= sel_we;
            io_addr <= sel_addr;
            io_dout <= sel_wdata;
            io_wr   <= sel_we;
            io_rd   <= ~sel_we;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          io_wr <= 1'b0;
          io_rd <= 1'b0;
          if (own_b) begin
            b_rdata <= we_q ? '0 : io_din;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= we_q ? '0 : io_din;
            a_ack   <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          io_addr <= '0;
          io_dout <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_io_arbiter.sv
// Directed bench for csr_io_arbiter: table of single transactions plus hand-written
// contention, reset and withdrawn-request sequences on round-robin and fixed-priority instances.
module tb_csr_io_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic [15:0] io_din = 16'hdead;

  logic        a_ack, b_ack, io_wr, io_rd, busy;
  logic [15:0] a_rdata, b_rdata, io_addr, io_dout;
  logic        f_a_ack, f_b_ack, f_io_wr, f_io_rd, f_busy;
  logic [15:0] f_a_rdata, f_b_rdata, f_io_addr, f_io_dout;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] model_a_rd, model_b_rd;

  always #5 clk = ~clk;

  csr_io_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .io_addr(io_addr), .io_dout(io_dout), .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .busy(busy)
  );

  csr_io_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
    .io_addr(f_io_addr), .io_dout(f_io_dout), .io_wr(f_io_wr), .io_rd(f_io_rd), .io_din(io_din), .busy(f_busy)
  );

  typedef struct {
    logic        from_b;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    io_din = 16'hdead;
    model_a_rd = '0; model_b_rd = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One isolated transaction with cycle-by-cycle checks of strobe, ack and data timing.
  task automatic txn(input int idx, input vec_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    if (v.from_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    tick();
    io_din = v.din;
    check({p, "_issue_rd"}, {15'd0, io_rd}, {15'd0, ~v.we});
    check({p, "_issue_wr"}, {15'd0, io_wr}, {15'd0, v.we});
    check({p, "_issue_addr"}, io_addr, v.addr);
    check({p, "_issue_dout"}, io_dout, v.wdata);
    check({p, "_issue_busy"}, {15'd0, busy}, 16'd1);
    check({p, "_issue_acks"}, {14'd0, a_ack, b_ack}, 16'd0);
    tick();
    io_din = 16'hdead;
    if (v.from_b) model_b_rd = v.exp_rdata;
    else model_a_rd = v.exp_rdata;
    check({p, "_ack_acks"}, {14'd0, a_ack, b_ack}, v.from_b ? 16'd1 : 16'd2);
    check({p, "_ack_a_rdata"}, a_rdata, model_a_rd);
    check({p, "_ack_b_rdata"}, b_rdata, model_b_rd);
    check({p, "_ack_strobes"}, {14'd0, io_rd, io_wr}, 16'd0);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check({p, "_idle_busy_acks"}, {13'd0, busy, a_ack, b_ack}, 16'd0);
    check({p, "_idle_addr"}, io_addr, 16'd0);
    check({p, "_idle_a_rdata_hold"}, a_rdata, model_a_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int adjacent;
    logic prev_strobe;
    int stray;

    vecs[0] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h005A, 16'h005A};
    vecs[1] = '{1'b1, 1'b1, 16'h0008, 16'h00A5, 16'h1111, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h2222, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{1'b0, 1'b0, 16'h8001, 16'h0000, 16'hC3C3, 16'hC3C3};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000};

    do_reset();
    check("reset_outputs", {10'd0, io_wr, io_rd, a_ack, b_ack, busy, 1'b0}, 16'd0);
    check("reset_io_addr", io_addr, 16'd0);
    check("reset_io_dout", io_dout, 16'd0);
    check("reset_rdata", a_rdata | b_rdata, 16'd0);

    for (int i = 0; i < 6; i++) txn(i, vecs[i]);

    // Round-robin contention: A reads, B writes, both held for 12 cycles.
    do_reset();
    a_we = 1'b0; a_addr = 16'h0004; b_we = 1'b1; b_addr = 16'h0008; b_wdata = 16'h00A5;
    io_din = 16'h0077;
    a_req = 1'b1; b_req = 1'b1;
    strobes = 0; adjacent = 0; prev_strobe = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("rr_a_ack_c%0d", k), {15'd0, a_ack}, (k == 2 || k == 8) ? 16'd1 : 16'd0);
      check($sformatf("rr_b_ack_c%0d", k), {15'd0, b_ack}, (k == 5 || k == 11) ? 16'd1 : 16'd0);
      if (io_rd || io_wr) begin
        strobes++;
        if (prev_strobe) adjacent++;
      end
      prev_strobe = io_rd | io_wr;
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr_strobe_count", 16'(strobes), 16'd4);
    check("rr_adjacent_strobes", 16'(adjacent), 16'd0);
    check("rr_a_rdata", a_rdata, 16'h0077);
    check("rr_b_rdata", b_rdata, 16'h0000);

    // Fixed priority contention, both held for 9 cycles.
    do_reset();
    a_we = 1'b0; b_we = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("fp_a_ack_c%0d", k), {15'd0, f_a_ack}, (k == 2 || k == 5 || k == 8) ? 16'd1 : 16'd0);
      check($sformatf("fp_b_ack_c%0d", k), {15'd0, f_b_ack}, 16'd0);
    end
    a_req = 1'b0; b_req = 1'b0;

    // Reset during ISSUE of an A read, after a_rdata already holds data.
    do_reset();
    vecs[0].din = 16'h1234; vecs[0].exp_rdata = 16'h1234;
    txn(6, vecs[0]);
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0004;
    tick();
    check("rst_pre_issue_rd", {15'd0, io_rd}, 16'd1);
    rst = 1'b0;
    #1;
    check("rst_async_flags", {12'd0, io_rd, a_ack, busy, io_wr}, 16'd0);
    check("rst_async_a_rdata", a_rdata, 16'd0);
    check("rst_async_io_addr", io_addr, 16'd0);
    tick();
    rst = 1'b1;
    io_din = 16'h4321;
    tick();
    check("rst_retry_issue_rd", {15'd0, io_rd}, 16'd1);
    check("rst_retry_addr", io_addr, 16'h0004);
    tick();
    io_din = 16'hdead;
    check("rst_retry_ack", {14'd0, a_ack, b_ack}, 16'd2);
    check("rst_retry_rdata", a_rdata, 16'h4321);
    a_req = 1'b0;

    // B request pulsed during A's ACK cycle must be ignored.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0004;
    tick();
    tick();
    check("wd_a_ack", {15'd0, a_ack}, 16'd1);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0008; b_wdata = 16'h00A5;
    tick();
    b_req = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      if (io_wr || io_rd || b_ack) stray++;
      tick();
    end
    check("wd_no_b_activity", 16'(stray), 16'd0);
    check("wd_b_rdata", b_rdata, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
